// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC widths and readout state encoding
package mac_pkg;
  localparam int ACC_W  = 512;
  localparam int WORD_W = 32;
  localparam int NWORDS = ACC_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS + 1);
  localparam int SEL_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NWORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } rdout_state_t;
endpackage

// File: rtl/mac_readout_serializer.sv
// rtl/mac_readout_serializer.sv - accumulator snapshot streamed LSW-first as 32-bit beats
// Optional XOR checksum beat after the last data word: MAC_RDOUT_CSUM_EN.
module mac_readout_serializer
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              snap_req,
  output logic              busy,
  output logic              snap_drop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last
);

  rdout_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  snap_q, snap_d;
  logic              drop_q, drop_d;
  logic              xfer, final_xfer, accept;
  logic [WORD_W-1:0] words [NWORDS];
  logic [WORD_W-1:0] cur_word;
`ifdef MAC_RDOUT_CSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;
`endif

  always_comb begin
    for (int k = 0; k < NWORDS; k++) begin
      words[k] = snap_q[k*WORD_W +: WORD_W];
    end
  end

  assign cur_word = words[idx_q[SEL_W-1:0]];

  assign busy    = (state_q != IDLE);
  assign m_valid = (state_q != IDLE);

  always_comb begin
    m_data = '0;
    m_idx  = '0;
    m_last = 1'b0;
    case (state_q)
      SEND: begin
        m_data = cur_word;
        m_idx  = idx_q;
`ifndef MAC_RDOUT_CSUM_EN
        m_last = (idx_q == LAST_IDX);
`endif
      end
`ifdef MAC_RDOUT_CSUM_EN
      CSUM: begin
        m_data = csum_q;
        m_idx  = idx_q;
        m_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign xfer       = m_valid && m_ready;
  assign final_xfer = xfer && m_last;
  // A request is only taken when no frame will be held after this edge.
  assign accept     = snap_req && ((state_q == IDLE) || final_xfer);
  assign snap_drop  = drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    drop_d  = snap_req && !accept;
`ifdef MAC_RDOUT_CSUM_EN
    csum_d  = csum_q;
`endif
    if (xfer) begin
      case (state_q)
        SEND: begin
          idx_d = idx_q + 1'b1;
`ifdef MAC_RDOUT_CSUM_EN
          csum_d = csum_q ^ cur_word;
          if (idx_q == LAST_IDX) state_d = CSUM;
`else
          if (idx_q == LAST_IDX) state_d = IDLE;
`endif
        end
        CSUM:    state_d = IDLE;
        default: ;
      endcase
    end
    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
      snap_d  = acc_in;
`ifdef MAC_RDOUT_CSUM_EN
      csum_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      drop_q  <= drop_d;
    end
  end

`ifdef MAC_RDOUT_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

endmodule

// File: tb/tb_mac_readout_serializer.sv
// tb/tb_mac_readout_serializer.sv - directed and random bench against a beat-queue model
module tb_mac_readout_serializer;
  import mac_pkg::*;

`ifdef MAC_RDOUT_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ACC_W-1:0]  acc_in = '0;
  logic              snap_req = 1'b0;
  logic              busy, snap_drop, m_valid, m_last;
  logic              m_ready = 1'b0;
  logic [WORD_W-1:0] m_data;
  logic [IDX_W-1:0]  m_idx;

  mac_readout_serializer dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .snap_req(snap_req),
    .busy(busy), .snap_drop(snap_drop), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_drop = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    dut_drops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A frame is the snapshot's words in ascending order, plus an XOR beat when enabled.
  task automatic push_frame(input logic [ACC_W-1:0] acc);
    beat_t b;
    logic [WORD_W-1:0] x;
    x = '0;
    for (int k = 0; k < NWORDS; k++) begin
      b.data = acc[k*WORD_W +: WORD_W];
      b.idx  = IDX_W'(k);
      b.last = (k == NWORDS - 1) && !CSUM_EN;
      x      = x ^ b.data;
      exp_q.push_back(b);
    end
    if (CSUM_EN) begin
      b.data = x;
      b.idx  = IDX_W'(NWORDS);
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [ACC_W-1:0] rand_acc();
    logic [ACC_W-1:0] v;
    for (int k = 0; k < NWORDS; k++) v[k*WORD_W +: WORD_W] = $urandom;
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] pat_acc();
    logic [ACC_W-1:0] v;
    for (int k = 0; k < NWORDS; k++) v[k*WORD_W +: WORD_W] = 32'h1000_0000 + k;
    return v;
  endfunction

  // Called just after a falling edge; checks outputs, then advances the model across one rising edge.
  task automatic step(input logic req, input logic rdy, input logic [ACC_W-1:0] acc);
    logic valid_m, xfer, fin, take;
    snap_req = req;
    m_ready  = rdy;
    acc_in   = acc;
    #1;
    valid_m = (exp_q.size() != 0);
    chk("m_valid", m_valid, valid_m);
    chk("busy", busy, valid_m);
    chk("snap_drop", snap_drop, exp_drop);
    if (snap_drop === 1'b1) dut_drops++;
    if (valid_m) begin
      chk("m_data", m_data, exp_q[0].data);
      chk("m_idx", m_idx, exp_q[0].idx);
      chk("m_last", m_last, exp_q[0].last);
    end
    xfer = valid_m && rdy;
    fin  = xfer && exp_q[0].last;
    take = req && (!valid_m || fin);
    if (xfer) void'(exp_q.pop_front());
    exp_drop = req && !take;
    if (take) push_frame(acc);
    @(negedge clk);
  endtask

  task automatic drain(input int max_steps);
    for (int i = 0; i < max_steps && exp_q.size() != 0; i++) step(1'b0, 1'b1, rand_acc());
    chk("drained", exp_q.size(), 0);
  endtask

  logic [ACC_W-1:0] v;
  int d0;
  logic [3:0] rdy_pat;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_idx", m_idx, 0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_drop", snap_drop, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, rand_acc());

    // Counting pattern at full rate, then idle cycles to see busy drop.
    step(1'b1, 1'b1, pat_acc());
    drain(40);
    repeat (3) step(1'b0, 1'b1, rand_acc());

    // Same frame under a 1,0,0,1 ready pattern.
    rdy_pat = 4'b1001;
    step(1'b1, 1'b0, pat_acc());
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step(1'b0, rdy_pat[i % 4], rand_acc());
    chk("stall_drained", exp_q.size(), 0);

    // Request mid-frame is dropped; request on final beat starts next frame with no bubble.
    v = rand_acc();
    step(1'b1, 1'b1, v);
    repeat (5) step(1'b0, 1'b1, rand_acc());
    d0 = dut_drops;
    step(1'b1, 1'b1, rand_acc());
    for (int i = 0; i < 40 && exp_q.size() != 0; i++)
      step(exp_q.size() == 1, 1'b1, rand_acc());
    chk("drop_count", dut_drops - d0, 1);
    drain(40);

    // Asynchronous reset while stalled on beat 7.
    step(1'b1, 1'b1, rand_acc());
    repeat (7) step(1'b0, 1'b1, rand_acc());
    repeat (2) step(1'b0, 1'b0, rand_acc());
    #1;
    chk("pre_rst_idx", m_idx, 7);
    rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_data", m_data, 32'h0);
    chk("arst_idx", m_idx, 0);
    chk("arst_last", m_last, 1'b0);
    chk("arst_drop", snap_drop, 1'b0);
    exp_q.delete();
    exp_drop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, rand_acc());
    step(1'b1, 1'b1, rand_acc());
    drain(40);

    // Checksum corner inputs.
    step(1'b1, 1'b1, {ACC_W{1'b1}});
    drain(40);
    v = '0;
    v[WORD_W-1:0] = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, v);
    drain(40);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 6) == 0, ($urandom % 3) != 0, rand_acc());
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
